// File: rtl/reg_writeback_unit_pkg.sv
// rtl/reg_writeback_unit_pkg.sv - shared types, special register ids and the writable() check
package reg_writeback_unit_pkg;

   localparam int DATA_WIDTH = 32;
   typedef logic [DATA_WIDTH-1:0] data_t;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_LSU = 1'b1
   } wb_src_t;

   localparam logic [4:0] THREAD_ID_REG  = 5'd29;
   localparam logic [4:0] BLOCK_ID_REG   = 5'd30;
   localparam logic [4:0] BLOCK_SIZE_REG = 5'd31;

   // x0 is hardwired; the special ids are filled by the register file itself
   function automatic logic writable(input logic [4:0] rd, input logic has_special);
      if (rd == 5'd0)
         return 1'b0;
      if (has_special && (rd == THREAD_ID_REG || rd == BLOCK_ID_REG || rd == BLOCK_SIZE_REG))
         return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/reg_writeback_unit_scoreboard.sv
// rtl/reg_writeback_unit_scoreboard.sv - per-warp pending bits, outstanding counters, hazard/idle outputs
module wb_scoreboard
   import reg_writeback_unit_pkg::*;
#(
   parameter int NUM_WARPS        = 4,
   parameter int WARP_W           = $clog2(NUM_WARPS),
   parameter bit HAS_SPECIAL_REGS = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 issue_valid,
   input  logic [WARP_W-1:0]    issue_warp,
   input  logic [4:0]           issue_rd,
   input  logic                 issue_writes_rd,
   input  logic                 clr_valid,
   input  logic [WARP_W-1:0]    clr_warp,
   input  logic [4:0]           clr_rd,
   input  logic [WARP_W-1:0]    chk_warp,
   input  logic [4:0]           chk_rs1,
   input  logic [4:0]           chk_rs2,
   input  logic [4:0]           chk_rd,
   output logic                 chk_hazard,
   output logic [NUM_WARPS-1:0] warp_idle
);

   logic [NUM_WARPS-1:0][31:0] pending;
   logic [NUM_WARPS-1:0][5:0]  outstanding;
   logic                       set_en;
   logic [NUM_WARPS-1:0]       set_hit;
   logic [NUM_WARPS-1:0]       clr_hit;

   assign set_en = issue_valid & issue_writes_rd & writable(issue_rd, HAS_SPECIAL_REGS);

   always_comb begin
      set_hit   = '0;
      clr_hit   = '0;
      warp_idle = '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
         set_hit[w]   = set_en & (issue_warp == WARP_W'(w));
         clr_hit[w]   = clr_valid & (clr_warp == WARP_W'(w));
         warp_idle[w] = (outstanding[w] == 6'd0);
      end
   end

   assign chk_hazard = pending[chk_warp][chk_rs1] | pending[chk_warp][chk_rs2]
                     | (pending[chk_warp][chk_rd] & writable(chk_rd, HAS_SPECIAL_REGS));

   // Set is applied after clear so a same-target retire/issue leaves the bit set
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending     <= '0;
         outstanding <= '0;
      end else begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            if (clr_hit[w])
               pending[w][clr_rd] <= 1'b0;
            if (set_hit[w])
               pending[w][issue_rd] <= 1'b1;
            case ({set_hit[w], clr_hit[w]})
               2'b10:   outstanding[w] <= outstanding[w] + 6'd1;
               2'b01:   outstanding[w] <= outstanding[w] - 6'd1;
               default: outstanding[w] <= outstanding[w];
            endcase
         end
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (reset_n) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            assert (!(clr_hit[w] && !set_hit[w] && outstanding[w] == 6'd0))
               else $error("wb_scoreboard: warp %0d outstanding underflow", w);
            assert (!(set_hit[w] && !clr_hit[w] && outstanding[w] >= 6'd32))
               else $error("wb_scoreboard: warp %0d outstanding overflow", w);
         end
      end
   end
`endif

endmodule

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - round-robin ALU/LSU result arbiter with registered register-file write port
module reg_writeback_unit
   import reg_writeback_unit_pkg::*;
#(
   parameter int THREADS_PER_WARP = 16,
   parameter int NUM_WARPS        = 4,
   parameter int WARP_W           = $clog2(NUM_WARPS),
   parameter bit HAS_SPECIAL_REGS = 1'b1
) (
   input  logic                                        clk,
   input  logic                                        reset_n,
   input  logic                                        alu_valid,
   output logic                                        alu_ready,
   input  logic [WARP_W-1:0]                           alu_warp,
   input  logic [4:0]                                  alu_rd,
   input  logic [THREADS_PER_WARP-1:0]                 alu_mask,
   input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] alu_data,
   input  logic                                        lsu_valid,
   output logic                                        lsu_ready,
   input  logic [WARP_W-1:0]                           lsu_warp,
   input  logic [4:0]                                  lsu_rd,
   input  logic [THREADS_PER_WARP-1:0]                 lsu_mask,
   input  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] lsu_data,
   input  logic                                        issue_valid,
   input  logic [WARP_W-1:0]                           issue_warp,
   input  logic [4:0]                                  issue_rd,
   input  logic                                        issue_writes_rd,
   input  logic [WARP_W-1:0]                           chk_warp,
   input  logic [4:0]                                  chk_rs1,
   input  logic [4:0]                                  chk_rs2,
   input  logic [4:0]                                  chk_rd,
   output logic                                        chk_hazard,
   output logic [NUM_WARPS-1:0]                        warp_idle,
   output logic                                        wb_valid,
   output logic [WARP_W-1:0]                           wb_warp,
   output logic [4:0]                                  wb_rd,
   output logic [THREADS_PER_WARP-1:0]                 wb_mask,
   output logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] wb_data
);

   logic                                        rr_ptr;
   wb_src_t                                     win_src;
   logic                                        grant;
   logic                                        both_valid;
   logic [WARP_W-1:0]                           sel_warp;
   logic [4:0]                                  sel_rd;
   logic [THREADS_PER_WARP-1:0]                 sel_mask;
   logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] sel_data;

   assign both_valid = alu_valid & lsu_valid;
   assign grant      = alu_valid | lsu_valid;

   always_comb begin
      win_src = WB_SRC_ALU;
      if (both_valid)
         win_src = rr_ptr ? WB_SRC_LSU : WB_SRC_ALU;
      else if (lsu_valid)
         win_src = WB_SRC_LSU;
   end

   assign alu_ready = reset_n & alu_valid & (win_src == WB_SRC_ALU);
   assign lsu_ready = reset_n & lsu_valid & (win_src == WB_SRC_LSU);

   always_comb begin
      sel_warp = alu_warp;
      sel_rd   = alu_rd;
      sel_mask = alu_mask;
      sel_data = alu_data;
      if (win_src == WB_SRC_LSU) begin
         sel_warp = lsu_warp;
         sel_rd   = lsu_rd;
         sel_mask = lsu_mask;
         sel_data = lsu_data;
      end
   end

   // Non-writable destinations are consumed but never strobe the register file
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr   <= 1'b0;
         wb_valid <= 1'b0;
         wb_warp  <= '0;
         wb_rd    <= '0;
         wb_mask  <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= grant & writable(sel_rd, HAS_SPECIAL_REGS);
         if (grant) begin
            wb_warp <= sel_warp;
            wb_rd   <= sel_rd;
            wb_mask <= sel_mask;
            wb_data <= sel_data;
         end
         if (both_valid)
            rr_ptr <= (win_src == WB_SRC_ALU);
      end
   end

   wb_scoreboard #(
      .NUM_WARPS        (NUM_WARPS),
      .WARP_W           (WARP_W),
      .HAS_SPECIAL_REGS (HAS_SPECIAL_REGS)
   ) u_scoreboard (
      .clk             (clk),
      .reset_n         (reset_n),
      .issue_valid     (issue_valid),
      .issue_warp      (issue_warp),
      .issue_rd        (issue_rd),
      .issue_writes_rd (issue_writes_rd),
      .clr_valid       (wb_valid),
      .clr_warp        (wb_warp),
      .clr_rd          (wb_rd),
      .chk_warp        (chk_warp),
      .chk_rs1         (chk_rs1),
      .chk_rs2         (chk_rs2),
      .chk_rd          (chk_rd),
      .chk_hazard      (chk_hazard),
      .warp_idle       (warp_idle)
   );

endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb/tb_reg_writeback_unit.sv - directed self-checking bench for reg_writeback_unit
module tb_reg_writeback_unit;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                alu_valid, alu_ready, lsu_valid, lsu_ready;
   logic [1:0]          alu_warp, lsu_warp, issue_warp, chk_warp, wb_warp;
   logic [4:0]          alu_rd, lsu_rd, issue_rd, chk_rs1, chk_rs2, chk_rd, wb_rd;
   logic [15:0]         alu_mask, lsu_mask, wb_mask;
   logic [15:0][31:0]   alu_data, lsu_data, wb_data;
   logic                issue_valid, issue_writes_rd, chk_hazard, wb_valid;
   logic [3:0]          warp_idle;
   int                  n_tests = 0;
   int                  n_fail  = 0;

   always #5 clk = ~clk;

   reg_writeback_unit dut (
      .clk(clk), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_warp(alu_warp), .alu_rd(alu_rd),
      .alu_mask(alu_mask), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_warp(lsu_warp), .lsu_rd(lsu_rd),
      .lsu_mask(lsu_mask), .lsu_data(lsu_data),
      .issue_valid(issue_valid), .issue_warp(issue_warp), .issue_rd(issue_rd),
      .issue_writes_rd(issue_writes_rd),
      .chk_warp(chk_warp), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
      .chk_hazard(chk_hazard), .warp_idle(warp_idle),
      .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_rd(wb_rd), .wb_mask(wb_mask), .wb_data(wb_data)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0][31:0] mkdata(input logic [31:0] base);
      logic [15:0][31:0] d;
      for (int i = 0; i < 16; i++)
         d[i] = base + 32'(i);
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] w, input logic [4:0] rd);
      issue_valid = 1'b1; issue_warp = w; issue_rd = rd; issue_writes_rd = 1'b1;
      tick();
      issue_valid = 1'b0;
   endtask

   task automatic drive_alu(input logic [1:0] w, input logic [4:0] rd, input logic [15:0] m,
                            input logic [31:0] base);
      alu_valid = 1'b1; alu_warp = w; alu_rd = rd; alu_mask = m; alu_data = mkdata(base);
   endtask

   task automatic drive_lsu(input logic [1:0] w, input logic [4:0] rd, input logic [15:0] m,
                            input logic [31:0] base);
      lsu_valid = 1'b1; lsu_warp = w; lsu_rd = rd; lsu_mask = m; lsu_data = mkdata(base);
   endtask

   task automatic query(input logic [1:0] w, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd);
      chk_warp = w; chk_rs1 = rs1; chk_rs2 = rs2; chk_rd = rd;
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      alu_valid = 1'b1; alu_warp = '0; alu_rd = 5'd1; alu_mask = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_warp = '0; lsu_rd = '0; lsu_mask = '0; lsu_data = '0;
      issue_valid = 1'b0; issue_warp = '0; issue_rd = '0; issue_writes_rd = 1'b0;
      chk_warp = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
      tick();
      tick();
      check("rst_alu_ready", alu_ready, 0);
      check("rst_wb_valid", wb_valid, 0);
      check("rst_wb_payload", {wb_warp, wb_rd, wb_mask}, 0);
      check("rst_idle", warp_idle, 4'hF);
      check("rst_hazard", chk_hazard, 0);
      alu_valid = 1'b0;
      reset_n = 1'b1;

      // single ALU result
      issue(2'd2, 5'd5);
      check("t1_idle_busy", warp_idle, 4'b1011);
      query(2'd2, 5'd5, 5'd0, 5'd0);
      check("t1_hazard_set", chk_hazard, 1);
      drive_alu(2'd2, 5'd5, 16'hFFFF, 32'd0);
      #1;
      check("t1_alu_ready", alu_ready, 1);
      check("t1_lsu_ready", lsu_ready, 0);
      tick();
      alu_valid = 1'b0;
      check("t1_wb_valid", wb_valid, 1);
      check("t1_wb_warp_rd", {wb_warp, wb_rd}, {2'd2, 5'd5});
      check("t1_wb_mask", wb_mask, 16'hFFFF);
      check("t1_wb_data", wb_data, mkdata(32'd0));
      check("t1_hazard_hold", chk_hazard, 1);
      tick();
      check("t1_wb_pulse", wb_valid, 0);
      check("t1_hazard_clr", chk_hazard, 0);
      check("t1_idle_back", warp_idle, 4'hF);

      // dual-valid round robin
      issue(2'd0, 5'd1);
      issue(2'd0, 5'd2);
      issue(2'd0, 5'd3);
      issue(2'd0, 5'd4);
      check("t2_idle_busy", warp_idle, 4'b1110);
      drive_alu(2'd0, 5'd1, 16'h00FF, 32'd100);
      drive_lsu(2'd0, 5'd2, 16'h0F0F, 32'd200);
      #1;
      check("t2_g1_ready", {alu_ready, lsu_ready}, 2'b10);
      tick();
      check("t2_g1_wb", {wb_valid, wb_rd}, {1'b1, 5'd1});
      check("t2_g1_data", wb_data, mkdata(32'd100));
      drive_alu(2'd0, 5'd3, 16'h00FF, 32'd300);
      #1;
      check("t2_g2_ready", {alu_ready, lsu_ready}, 2'b01);
      tick();
      check("t2_g2_wb", {wb_valid, wb_rd, wb_mask}, {1'b1, 5'd2, 16'h0F0F});
      check("t2_g2_data", wb_data, mkdata(32'd200));
      drive_lsu(2'd0, 5'd4, 16'h0F0F, 32'd400);
      #1;
      check("t2_g3_ready", {alu_ready, lsu_ready}, 2'b10);
      tick();
      check("t2_g3_wb", {wb_valid, wb_rd}, {1'b1, 5'd3});
      check("t2_g3_data", wb_data, mkdata(32'd300));
      drive_alu(2'd0, 5'd0, 16'h00FF, 32'd500);
      #1;
      check("t2_g4_ready", {alu_ready, lsu_ready}, 2'b01);
      tick();
      lsu_valid = 1'b0;
      check("t2_g4_wb", {wb_valid, wb_rd}, {1'b1, 5'd4});
      check("t2_g4_data", wb_data, mkdata(32'd400));
      #1;
      check("t2_g5_ready", {alu_ready, lsu_ready}, 2'b10);
      tick();
      alu_valid = 1'b0;
      check("t2_rd0_no_wb", wb_valid, 0);
      check("t2_idle_back", warp_idle, 4'hF);

      // hazard query and same-cycle set/clear
      issue(2'd1, 5'd7);
      query(2'd1, 5'd7, 5'd0, 5'd0);
      check("t3_hazard_rs1", chk_hazard, 1);
      query(2'd1, 5'd0, 5'd0, 5'd7);
      check("t3_hazard_rd", chk_hazard, 1);
      query(2'd1, 5'd8, 5'd6, 5'd9);
      check("t3_no_hazard", chk_hazard, 0);
      query(2'd0, 5'd7, 5'd0, 5'd0);
      check("t3_other_warp", chk_hazard, 0);
      query(2'd1, 5'd7, 5'd0, 5'd0);
      drive_alu(2'd1, 5'd7, 16'h0001, 32'd700);
      tick();
      alu_valid = 1'b0;
      check("t3_wb_first", {wb_valid, wb_warp, wb_rd}, {1'b1, 2'd1, 5'd7});
      issue(2'd1, 5'd7);
      check("t3_set_wins", chk_hazard, 1);
      check("t3_cnt_hold", warp_idle, 4'b1101);
      drive_alu(2'd1, 5'd7, 16'h0001, 32'd710);
      tick();
      alu_valid = 1'b0;
      check("t3_wb_second", {wb_valid, wb_rd}, {1'b1, 5'd7});
      tick();
      check("t3_drained_hazard", chk_hazard, 0);
      check("t3_drained_idle", warp_idle, 4'hF);

      // zero and special destinations
      issue(2'd0, 5'd0);
      issue(2'd0, 5'd30);
      issue(2'd0, 5'd31);
      check("t4_idle", warp_idle, 4'hF);
      query(2'd0, 5'd30, 5'd31, 5'd31);
      check("t4_no_hazard", chk_hazard, 0);
      drive_alu(2'd0, 5'd30, 16'hFFFF, 32'd30);
      #1;
      check("t4_alu_ready", alu_ready, 1);
      tick();
      alu_valid = 1'b0;
      check("t4_wb30", wb_valid, 0);
      drive_lsu(2'd0, 5'd31, 16'hFFFF, 32'd31);
      #1;
      check("t4_lsu_ready", lsu_ready, 1);
      tick();
      lsu_valid = 1'b0;
      check("t4_wb31", wb_valid, 0);
      check("t4_idle_after", warp_idle, 4'hF);

      // 20 outstanding writes drained through the LSU
      for (int r = 1; r <= 20; r++)
         issue(2'd3, 5'(r));
      check("t5_idle_busy", warp_idle, 4'b0111);
      query(2'd3, 5'd20, 5'd1, 5'd0);
      check("t5_hazard", chk_hazard, 1);
      for (int r = 1; r <= 20; r++) begin
         drive_lsu(2'd3, 5'(r), 16'hAAAA, 32'(r * 16));
         tick();
         check("t5_wb", {wb_valid, wb_warp, wb_rd}, {1'b1, 2'd3, 5'(r)});
         check("t5_idle3_busy", warp_idle[3], 0);
      end
      lsu_valid = 1'b0;
      tick();
      check("t5_wb_end", wb_valid, 0);
      check("t5_idle_all", warp_idle, 4'hF);
      check("t5_hazard_clr", chk_hazard, 0);

      // reset mid-stream
      issue(2'd2, 5'd10);
      issue(2'd2, 5'd11);
      issue(2'd2, 5'd12);
      drive_alu(2'd2, 5'd10, 16'h1234, 32'd1000);
      drive_lsu(2'd2, 5'd0, 16'h0000, 32'd0);
      tick();
      drive_alu(2'd2, 5'd11, 16'h1234, 32'd1100);
      #1;
      check("t6_pre_wb", {wb_valid, wb_rd}, {1'b1, 5'd10});
      check("t6_pre_rr", {alu_ready, lsu_ready}, 2'b01);
      query(2'd2, 5'd11, 5'd12, 5'd10);
      reset_n = 1'b0;
      #1;
      check("t6_wb_drop", wb_valid, 0);
      check("t6_wb_payload", {wb_warp, wb_rd, wb_mask}, 0);
      check("t6_idle", warp_idle, 4'hF);
      check("t6_hazard", chk_hazard, 0);
      check("t6_ready_low", {alu_ready, lsu_ready}, 2'b00);
      tick();
      alu_rd = 5'd0;
      reset_n = 1'b1;
      #1;
      check("t6_rr_reset", {alu_ready, lsu_ready}, 2'b10);
      tick();
      alu_valid = 1'b0;
      lsu_valid = 1'b0;
      tick();
      check("t6_wb_quiet", wb_valid, 0);
      check("t6_idle_end", warp_idle, 4'hF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_writeback_unit.md
# reg_writeback_unit

Write-side front end for the per-warp register file. It accepts completed results from the ALU and LSU pipelines over valid/ready handshakes and arbitrates between them round-robin. It emits one registered write per cycle toward the register file. A per-warp scoreboard tracks pending destination registers so the issue stage can detect RAW/WAW hazards and warp drain.

## Interface
- THREADS_PER_WARP, 16, lanes per result vector
- DATA_WIDTH, `DATA_WIDTH`, bits per lane
- NUM_WARPS, 4, warps tracked by the scoreboard (power of two)
- WARP_W, $clog2(NUM_WARPS), warp index width
- HAS_SPECIAL_REGS, 1, when 1, x29–x31 are read-only and never scoreboarded
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- alu_valid / alu_ready  in / out  1  ALU result handshake
- alu_warp  in  WARP_W  warp of the ALU result
- alu_rd  in  5  destination register of the ALU result
- alu_mask  in  THREADS_PER_WARP  lane enables of the ALU result
- alu_data  in  data_t[THREADS_PER_WARP]  ALU result lanes
- lsu_valid / lsu_ready / lsu_warp / lsu_rd / lsu_mask / lsu_data: same as the ALU group, for LSU results
- issue_valid  in  1  issue stage dispatches an instruction this cycle
- issue_warp  in  WARP_W  warp of the issued instruction
- issue_rd  in  5  destination of the issued instruction
- issue_writes_rd  in  1  issued instruction writes a register
- chk_warp  in  WARP_W  hazard-query warp
- chk_rs1 / chk_rs2 / chk_rd  in  5 each  hazard-query register indices
- chk_hazard  out  1  combinational: any queried register is pending
- warp_idle  out  NUM_WARPS  per-warp outstanding count == 0
- wb_valid  out  1  write strobe to the register file
- wb_warp  out  WARP_W  warp of the write
- wb_rd  out  5  destination register of the write
- wb_mask  out  THREADS_PER_WARP  lane enables of the write
- wb_data  out  data_t[THREADS_PER_WARP]  write data lanes

## Operation
- **Handshake.** A source is accepted on a cycle where valid and ready are both high. Ready is combinational: high only when the source is the arbitration winner. The register file never back-pressures.
- **Arbitration.** rr_ptr (0=ALU, 1=LSU) selects the winner when both sources are valid. After a dual-valid grant, rr_ptr flips to the loser. With a single valid source, that source wins and rr_ptr is unchanged.
- **Writable destinations.** rd==0, and rd>=29 when HAS_SPECIAL_REGS=1, are not writable.
  - A result to a non-writable rd is still accepted.
  - It produces wb_valid=0 the next cycle and leaves scoreboard state unchanged.
- **Scoreboard set.** pending[w][r] sets on issue_valid & issue_writes_rd & writable(issue_rd). outstanding[w] (6 bits) increments by the same condition.
- **Scoreboard clear.** pending[wb_warp][wb_rd] clears when the write is emitted (wb_valid high). outstanding[wb_warp] decrements by the same condition.
- **Same-cycle set and clear.**
  - Same (warp, rd): set wins and the counter holds, since one instruction left and one entered.
  - Different targets: both apply.
- **Hazard query.** chk_hazard = pending[chk_warp][chk_rs1] | pending[chk_warp][chk_rs2] | (pending[chk_warp][chk_rd] & writable(chk_rd)). Index 0 never reports a hazard.
- **Error checks (simulation only).**
  - Decrement of a zero counter: $error.
  - Increment past 32: $error.

## Timing
- Accept-to-wb latency is 1 cycle. wb_* is registered, and wb_valid pulses for 1 cycle per write.
- Throughput is 1 result per cycle combined across both sources.
- Scoreboard and counter updates are visible to chk_hazard and warp_idle the cycle after the edge that causes them.
- Reset values:
  - wb_valid=0; wb_warp, wb_rd, wb_mask, wb_data all 0.
  - pending all 0; outstanding all 0, so warp_idle all 1.
  - rr_ptr=0 (ALU favoured first).
- Reset asserted mid-operation:
  - All state clears immediately and asynchronously.
  - An in-flight wb_valid drops without completing.
  - alu_ready and lsu_ready are 0 while reset_n=0.

## Structure
- Shared package (common.svh):
  - data_t and DATA_WIDTH, existing.
  - wb_src_t enum {WB_SRC_ALU, WB_SRC_LSU}.
  - Constants THREAD_ID_REG=29, BLOCK_ID_REG=30, BLOCK_SIZE_REG=31, so the writable() check matches the register file.
- One natural sub-module, wb_scoreboard: the pending bit array, the outstanding counters and the hazard/idle logic. The top level holds the arbiter and the output register.

## Test plan
- **Single ALU result.** ALU valid with warp 2, rd 5, mask 0xFFFF, lanes = lane index; issued rd 5 earlier. Response: alu_ready=1; next cycle wb_valid=1, wb_rd=5, data matches; pending[2][5] clears; warp_idle[2] returns to 1.
- **Dual-valid arbitration.** Both sources held valid for 4 cycles. Grants go ALU, LSU, ALU, LSU; each loser's ready stays 0 and its data is held stable until granted.
- **Hazard and same-cycle set/clear.**
  - Issue warp 1 rd 7, then query rs1=7: chk_hazard=1.
  - Write-back of warp 1 rd 7 in the same cycle as a new issue of warp 1 rd 7: pending stays 1 and the counter is unchanged.
- **Special/zero rd.** Issue and result for rd 0, rd 30 and rd 31 with HAS_SPECIAL_REGS=1. Results are accepted, wb_valid stays 0, no pending bit is set, and warp_idle stays 1.
- **Counter stress.** Issue 20 writes to warp 3 at distinct rds 1..20, then drain via the LSU. warp_idle[3]=0 until the 20th wb, then 1; no errors fire.
- **Reset mid-stream.** Drop reset_n for 1 cycle while wb_valid=1 and 3 writes are pending. Immediately after: wb_valid=0, all warp_idle=1, chk_hazard=0 for any query.
